// File: rtl/hazard_ctrl_if.sv
// Pipeline-side view of the hazard controller: hazard sources in, per-stage
// stall/flush controls and performance counters out.
interface hazard_ctrl_if;
  logic [4:0]  ID_rs1_addr;
  logic [4:0]  ID_rs2_addr;
  logic        ID_rs1_used;
  logic        ID_rs2_used;
  logic [4:0]  EX_rd_addr;
  logic        EX_MemRead;
  logic        EX_redirect;
  logic        MEM_MemAccess;
  logic        MEM_ioAccess;
  logic        io_ready;

  logic        pc_stall;
  logic        IF_ID_stall;
  logic        ID_EX_stall;
  logic        EX_MEM_stall;
  logic        IF_ID_flush;
  logic        ID_EX_flush;
  logic        MEM_WB_flush;
  logic        io_timeout;
  logic [31:0] stall_cycles;
  logic [31:0] flush_events;

  modport master (
    output ID_rs1_addr, ID_rs2_addr, ID_rs1_used, ID_rs2_used,
           EX_rd_addr, EX_MemRead, EX_redirect,
           MEM_MemAccess, MEM_ioAccess, io_ready,
    input  pc_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall,
           IF_ID_flush, ID_EX_flush, MEM_WB_flush,
           io_timeout, stall_cycles, flush_events
  );

  modport slave (
    input  ID_rs1_addr, ID_rs2_addr, ID_rs1_used, ID_rs2_used,
           EX_rd_addr, EX_MemRead, EX_redirect,
           MEM_MemAccess, MEM_ioAccess, io_ready,
    output pc_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall,
           IF_ID_flush, ID_EX_flush, MEM_WB_flush,
           io_timeout, stall_cycles, flush_events
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline sequencing: load-use bubbles, redirect squashes and
// multi-cycle MEM holds, with stall/flush performance counters.
module hazard_ctrl #(
  parameter int MEM_LAT    = 2,
  parameter int IO_TIMEOUT = 255
) (
  input logic          clk,
  input logic          rstn,
  hazard_ctrl_if.slave hz
);

  localparam logic [7:0] LAT_LAST     = 8'(MEM_LAT - 1);
  localparam logic [7:0] TIMEOUT_LAST = 8'(IO_TIMEOUT);
  localparam bit         LAT_HOLD     = (MEM_LAT > 1);

  typedef enum logic [1:0] {IDLE, LAT_WAIT, IO_WAIT} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        mem_hold;
  logic        timeout_rel;
  logic        load_use;
  logic        redirect_act;
  logic        pc_stall_c, if_id_stall_c, id_ex_stall_c, ex_mem_stall_c;
  logic        if_id_flush_c, id_ex_flush_c, mem_wb_flush_c;
  logic [31:0] stall_q, flush_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every always_comb output gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_hold    = 1'b0;
    timeout_rel = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hz.MEM_MemAccess && hz.MEM_ioAccess && !hz.io_ready) begin
          mem_hold = 1'b1;
          cnt_d    = 8'd1;
          state_d  = IO_WAIT;
        end else if (hz.MEM_MemAccess && !hz.MEM_ioAccess && LAT_HOLD) begin
          mem_hold = 1'b1;
          cnt_d    = 8'd1;
          state_d  = LAT_WAIT;
        end
      end
      LAT_WAIT: begin
        if (cnt_q == LAT_LAST) begin
          state_d = IDLE;
        end else begin
          mem_hold = 1'b1;
          cnt_d    = cnt_q + 8'd1;
        end
      end
      IO_WAIT: begin
        if (hz.io_ready) begin
          state_d = IDLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          timeout_rel = 1'b1;
          state_d     = IDLE;
        end else begin
          mem_hold = 1'b1;
          cnt_d    = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign load_use = hz.EX_MemRead && (hz.EX_rd_addr != 5'd0) &&
                    ((hz.ID_rs1_used && (hz.ID_rs1_addr == hz.EX_rd_addr)) ||
                     (hz.ID_rs2_used && (hz.ID_rs2_addr == hz.EX_rd_addr)));

  // Priority: MEM hold freezes everything (a redirect waits in ID/EX for the
  // release cycle), then redirect squashes, then the load-use bubble.
  always_comb begin
    pc_stall_c     = 1'b0;
    if_id_stall_c  = 1'b0;
    id_ex_stall_c  = 1'b0;
    ex_mem_stall_c = 1'b0;
    if_id_flush_c  = 1'b0;
    id_ex_flush_c  = 1'b0;
    mem_wb_flush_c = 1'b0;
    redirect_act   = 1'b0;
    if (rstn) begin
      if (mem_hold) begin
        pc_stall_c     = 1'b1;
        if_id_stall_c  = 1'b1;
        id_ex_stall_c  = 1'b1;
        ex_mem_stall_c = 1'b1;
        mem_wb_flush_c = 1'b1;
      end else if (hz.EX_redirect) begin
        if_id_flush_c = 1'b1;
        id_ex_flush_c = 1'b1;
        redirect_act  = 1'b1;
      end else if (load_use) begin
        pc_stall_c    = 1'b1;
        if_id_stall_c = 1'b1;
        id_ex_flush_c = 1'b1;
      end
    end
  end

  // NOTE: only control state and counters take reset; the datapath registers
  // these controls act on are qualified by the flush bubbles instead.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_q <= 32'd0;
      flush_q <= 32'd0;
    end else begin
      if (pc_stall_c)   stall_q <= stall_q + 32'd1;
      if (redirect_act) flush_q <= flush_q + 32'd1;
    end
  end

  assign hz.pc_stall     = pc_stall_c;
  assign hz.IF_ID_stall  = if_id_stall_c;
  assign hz.ID_EX_stall  = id_ex_stall_c;
  assign hz.EX_MEM_stall = ex_mem_stall_c;
  assign hz.IF_ID_flush  = if_id_flush_c;
  assign hz.ID_EX_flush  = id_ex_flush_c;
  assign hz.MEM_WB_flush = mem_wb_flush_c;
  assign hz.io_timeout   = rstn && timeout_rel;
  assign hz.stall_cycles = stall_q;
  assign hz.flush_events = flush_q;

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the five-stage pipeline CPU: produces per-stage stall and flush controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves three hazard classes:
- load-use data hazards;
- taken-branch/jump redirects;
- multi-cycle data-memory and MMIO accesses in MEM, sequenced by a small wait FSM.

It also keeps stall/flush performance counters.

## Interface
- MEM_LAT, 2: data-BRAM read latency in cycles (≥1); MEM stage holds MEM_LAT-1 extra cycles per non-IO access.
- IO_TIMEOUT, 255: maximum cycles to wait for io_ready before forced release (≥1, fits 8 bits).

- clk  in  1  system clock, all state updates on rising edge
- rstn  in  1  asynchronous active-low reset
- ID_rs1_addr, ID_rs2_addr  in  5 each  source registers of instruction in ID
- ID_rs1_used, ID_rs2_used  in  1 each  source actually read by ID instruction
- EX_rd_addr  in  5  destination of instruction in EX
- EX_MemRead  in  1  EX instruction is a load
- EX_redirect  in  1  EX instruction is a taken branch/jump (PC target valid this cycle)
- MEM_MemAccess  in  1  MEM instruction is a load or store
- MEM_ioAccess  in  1  MEM access targets MMIO (qualifies MEM_MemAccess)
- io_ready  in  1  MMIO access complete this cycle
- pc_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall  out  1 each  hold register contents
- IF_ID_flush, ID_EX_flush, MEM_WB_flush  out  1 each  load bubble (all control fields 0) at next edge
- io_timeout  out  1  one-cycle pulse on forced MMIO release
- stall_cycles  out  32  count of cycles with pc_stall=1
- flush_events  out  32  count of redirect flushes

## Operation
- FSM states: IDLE, LAT_WAIT, IO_WAIT; 8-bit counter cnt.
- IDLE: if MEM_MemAccess & MEM_ioAccess & ~io_ready, assert mem_hold, cnt←1, go IO_WAIT. If MEM_MemAccess & ~MEM_ioAccess & MEM_LAT>1, assert mem_hold, cnt←1, go LAT_WAIT. Otherwise no hold.
- LAT_WAIT: if cnt==MEM_LAT-1, release (mem_hold=0), go IDLE; else mem_hold=1, cnt++.
- IO_WAIT: if io_ready, release, go IDLE. Else if cnt==IO_TIMEOUT, release, pulse io_timeout, go IDLE. Else mem_hold=1, cnt++.
- mem_hold=1 → pc_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall all 1; MEM_WB_flush=1; all other flushes 0. Overrides everything below.
- Else if EX_redirect: IF_ID_flush=1, ID_EX_flush=1, no stalls (PC loads target). flush_events++.
- Else if load-use: EX_MemRead & EX_rd_addr≠0 & ((ID_rs1_used & rs1==EX_rd) | (ID_rs2_used & rs2==EX_rd)) → pc_stall=1, IF_ID_stall=1, ID_EX_flush=1.
- Otherwise all outputs 0.
- Redirect and load-use in the same cycle: redirect wins; the ID instruction is squashed.
- Redirect during mem_hold: suppressed. EX_redirect remains asserted from the held ID/EX and is acted on in the release cycle, so it is counted once.
- Counters wrap at 2^32.

## Timing
- Reset: state IDLE, cnt 0, stall_cycles 0, flush_events 0, io_timeout 0. All stall/flush outputs forced 0 while rstn low.
- Reset mid-wait: returns to IDLE immediately; the access is abandoned.
- Stall/flush outputs are combinational from state and current inputs, valid the same cycle; pipeline registers act at the next edge.
- Non-IO access: exactly MEM_LAT-1 hold cycles. MEM_LAT=1 gives zero.
- IO access: hold cycles = cycles until io_ready. io_ready in the first MEM cycle gives zero hold.
- Timeout: release in the cycle where cnt==IO_TIMEOUT, i.e. IO_TIMEOUT hold cycles then release.
- Release cycle: holds deasserted, so the MEM instruction advances to WB at the following edge.
- Load-use: one bubble cycle; the dependent instruction proceeds the next cycle when the load is in MEM.
- stall_cycles increments at the edge ending every cycle with pc_stall=1.

## Test plan
- Load-use: EX lw x5, ID add x6,x5,x7 (rs1 used) → one cycle pc_stall=IF_ID_stall=ID_EX_flush=1; stall_cycles=1. Same with EX_rd_addr=0 → no stall.
- Redirect+load-use same cycle → IF_ID_flush=ID_EX_flush=1, pc_stall=0, flush_events=1.
- MEM_LAT=3 load in MEM → mem_hold for exactly 2 cycles, MEM_WB_flush=1 in both, then release; stall_cycles=2.
- MMIO read with io_ready on 4th cycle → 3 hold cycles then release; io_timeout stays 0. io_ready never, IO_TIMEOUT=5 → 5 hold cycles, io_timeout pulses once in the release cycle.
- Redirect asserted during IO_WAIT → no flush until release cycle, then one flush, flush_events=1.
- Assert rstn=0 in LAT_WAIT → outputs 0 immediately; after release, state IDLE and counters 0.
